sha256_round_engine: RTL and testbench

- Consumer end of the message-schedule interface: accepts the 64 schedule words W[0..63] one per handshake, in index order, from the w-vector expansion stage.
- Runs one SHA-256 compression round per accepted word, then adds the working variables into the chaining value.
- Presents the 256-bit intermediate/final hash to the top-level controller.
- Sits between the w-vector expansion block and the digest output register in the SHA256 datapath.

---
 rtl/sha256_round_engine_if.sv | 15 +
 rtl/sha256_round_engine.sv | 156 +++++++++++++++
 tb/tb_sha256_round_engine.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_engine_if.sv
// Message-schedule handshake between the W-expansion stage (master) and the
// SHA-256 round engine (slave): one 32-bit schedule word per valid/ready beat.
interface sha256_round_engine_if #(
  parameter int W_LENGTH = 64
) ();
  localparam int IDX_W = $clog2(W_LENGTH) + 1;

  logic             w_valid;
  logic [31:0]      w_word;
  logic [IDX_W-1:0] w_index;
  logic             w_ready;

  modport master (output w_valid, w_word, w_index, input w_ready);
  modport slave  (input w_valid, w_word, w_index, output w_ready);
endinterface

// File: rtl/sha256_round_engine.sv
// SHA-256 compression: one round per accepted schedule word, then chaining-value
// update. Define W_ORDER_CHECK_EN to add the sticky w_index order check.
module sha256_round_engine #(
  parameter int W_LENGTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sha256_round_engine_if.slave        w_if,
  input  logic                        start_i,
  input  logic [255:0]                hash_i,
  output logic                        busy_o,
  output logic [$clog2(W_LENGTH):0]   round_index_o,
  output logic                        hash_valid_o,
  output logic [255:0]                hash_o
`ifdef W_ORDER_CHECK_EN
  ,
  output logic                        order_error_o
`endif
);

  localparam int CNT_W = $clog2(W_LENGTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(W_LENGTH - 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  state_e           state_q;
  logic [31:0]      v_q [8];   // working variables a..h
  logic [31:0]      h_q [8];   // chaining value H0..H7
  logic [CNT_W-1:0] round_q;
  logic             w_ready_q;
  logic             busy_q;
  logic             hash_valid_q;
  logic [255:0]     hash_q;

  logic        accept;
  logic [31:0] k_t, s0, s1, ch, maj, t1, t2;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign accept = w_if.w_valid && w_ready_q;

  always_comb begin
    // NOTE: every signal here is assigned on every pass, so no latch can form.
    k_t = K_ROM[round_q[CNT_W-2:0]];
    s1  = rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25);
    ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    s0  = rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22);
    maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
    t1  = v_q[7] + s1 + ch + k_t + w_if.w_word;
    t2  = s0 + maj;
  end

`ifdef W_ORDER_CHECK_EN
  logic order_error_q;
`else
  logic unused_w_index;
  assign unused_w_index = ^w_if.w_index;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      // NOTE: a..h and H are small flop arrays, not RAM; clearing them keeps an
      // aborted block from leaving stale partial state behind.
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= '0;
        h_q[i] <= '0;
      end
      round_q      <= '0;
      w_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      hash_valid_q <= 1'b0;
      hash_q       <= '0;
`ifdef W_ORDER_CHECK_EN
      order_error_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so the a..h shift reads pre-edge values.
      hash_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            for (int i = 0; i < 8; i++) begin
              h_q[i] <= hash_i[255-32*i -: 32];
              v_q[i] <= hash_i[255-32*i -: 32];
            end
            round_q   <= '0;
            w_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ROUND;
`ifdef W_ORDER_CHECK_EN
            order_error_q <= 1'b0;
`endif
          end
        end
        ROUND: begin
          if (accept) begin
            v_q[0]  <= t1 + t2;
            v_q[1]  <= v_q[0];
            v_q[2]  <= v_q[1];
            v_q[3]  <= v_q[2];
            v_q[4]  <= v_q[3] + t1;
            v_q[5]  <= v_q[4];
            v_q[6]  <= v_q[5];
            v_q[7]  <= v_q[6];
            round_q <= round_q + 1'b1;
`ifdef W_ORDER_CHECK_EN
            if (w_if.w_index != round_q) order_error_q <= 1'b1;
`endif
            if (round_q == LAST_IDX) begin
              w_ready_q <= 1'b0;
              state_q   <= FINAL;
            end
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) begin
            h_q[i]                <= h_q[i] + v_q[i];
            hash_q[255-32*i -: 32] <= h_q[i] + v_q[i];
          end
          hash_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          // A start arriving here is deliberately dropped; the block must restart from IDLE.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_if.w_ready  = w_ready_q;
  assign busy_o        = busy_q;
  assign round_index_o = round_q;
  assign hash_valid_o  = hash_valid_q;
  assign hash_o        = hash_q;
`ifdef W_ORDER_CHECK_EN
  assign order_error_o = order_error_q;
`endif

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: known-answer digests, stalls, chaining,
// reset abort, ignored starts and (with W_ORDER_CHECK_EN) the order check.
module tb_sha256_round_engine;
  localparam int W_LENGTH = 64;
  localparam int IDX_W    = $clog2(W_LENGTH) + 1;

  localparam logic [255:0] IV         = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [255:0]     hash_in = '0;
  logic             busy;
  logic [IDX_W-1:0] round_index;
  logic             hash_valid;
  logic [255:0]     hash_out;
`ifdef W_ORDER_CHECK_EN
  logic             order_error;
`endif

  sha256_round_engine_if #(.W_LENGTH(W_LENGTH)) w_if ();

  sha256_round_engine #(.W_LENGTH(W_LENGTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .w_if          (w_if),
    .start_i       (start),
    .hash_i        (hash_in),
    .busy_o        (busy),
    .round_index_o (round_index),
    .hash_valid_o  (hash_valid),
    .hash_o        (hash_out)
`ifdef W_ORDER_CHECK_EN
    ,
    .order_error_o (order_error)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] w_sched [64];

  // Results of the most recent run_block call.
  bit           blk_valid, blk_stopped, blk_ready_c1, blk_busy_c1, blk_busy_done;
  int           blk_cycles, blk_ri_bad, blk_bad_cycle, blk_oe_first;
  bit           blk_oe_any, blk_oe_done;
  logic [255:0] blk_digest;
  logic [IDX_W-1:0] blk_ri_done;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic expand();
    for (int t = 16; t < 64; t++)
      w_sched[t] = ssig1(w_sched[t-2]) + w_sched[t-7] + ssig0(w_sched[t-15]) + w_sched[t-16];
  endtask

  task automatic load_abc();
    for (int t = 0; t < 16; t++) w_sched[t] = 32'h0;
    w_sched[0]  = 32'h61626380;
    w_sched[15] = 32'h00000018;
    expand();
  endtask

  task automatic load_msg1();
    w_sched[0]  = 32'h61626364; w_sched[1]  = 32'h62636465; w_sched[2]  = 32'h63646566;
    w_sched[3]  = 32'h64656667; w_sched[4]  = 32'h65666768; w_sched[5]  = 32'h66676869;
    w_sched[6]  = 32'h6768696a; w_sched[7]  = 32'h68696a6b; w_sched[8]  = 32'h696a6b6c;
    w_sched[9]  = 32'h6a6b6c6d; w_sched[10] = 32'h6b6c6d6e; w_sched[11] = 32'h6c6d6e6f;
    w_sched[12] = 32'h6d6e6f70; w_sched[13] = 32'h6e6f7071; w_sched[14] = 32'h80000000;
    w_sched[15] = 32'h00000000;
    expand();
  endtask

  task automatic load_msg2();
    for (int t = 0; t < 16; t++) w_sched[t] = 32'h0;
    w_sched[15] = 32'h000001c0;
    expand();
  endtask

  // Starts a block and streams w_sched. Cycle 0 is the start cycle; c counts cycles after it.
  // Returns on hash_valid, when abort_at words have been accepted, or after a cycle budget.
  task automatic run_block(input logic [255:0] hv, input bit stall, input int start_at,
                           input int abort_at, input int bad_at);
    int idx;
    int c;
    bit pulsed;
    bit v;
    idx = 0; c = 1; pulsed = 1'b0;
    blk_valid = 1'b0; blk_stopped = 1'b0; blk_cycles = -1; blk_ri_bad = 0;
    blk_digest = '0; blk_bad_cycle = -1; blk_oe_first = -1; blk_oe_any = 1'b0; blk_oe_done = 1'b0;
    blk_busy_done = 1'b0; blk_ri_done = '0;
    start = 1'b1; hash_in = hv; w_if.w_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    blk_ready_c1 = w_if.w_ready;
    blk_busy_c1  = busy;
    while (c < 600) begin
      if (round_index !== IDX_W'(idx)) blk_ri_bad++;
`ifdef W_ORDER_CHECK_EN
      if (order_error === 1'b1) begin
        blk_oe_any = 1'b1;
        if (blk_oe_first < 0) blk_oe_first = c;
      end
`endif
      if (hash_valid === 1'b1) begin
        blk_valid = 1'b1; blk_cycles = c; blk_digest = hash_out;
        blk_busy_done = busy; blk_ri_done = round_index;
`ifdef W_ORDER_CHECK_EN
        blk_oe_done = order_error;
`endif
        break;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        blk_stopped = 1'b1;
        break;
      end
      if (start_at >= 0 && idx == start_at && !pulsed) begin
        start = 1'b1; hash_in = ~hv; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      v = stall ? ($urandom_range(1) == 1) : 1'b1;
      w_if.w_valid = v;
      w_if.w_word  = w_sched[(idx < 64) ? idx : 63];
      w_if.w_index = IDX_W'(idx);
      if (idx == bad_at) begin
        w_if.w_index = IDX_W'(idx + 1);
        if (v && w_if.w_ready === 1'b1) blk_bad_cycle = c;
      end
      if (v && w_if.w_ready === 1'b1) idx++;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    w_if.w_valid = 1'b0;
  endtask

  task automatic test_reset();
    w_if.w_valid = 1'b0; w_if.w_word = '0; w_if.w_index = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (w_if.w_ready !== 1'b0) begin failures++; $display("FAIL reset_w_ready: got %b want 0", w_if.w_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hash_valid !== 1'b0) begin failures++; $display("FAIL reset_hash_valid: got %b want 0", hash_valid); end
    checks++; if (hash_out !== 256'h0) begin failures++; $display("FAIL reset_hash_out: got %h want 0", hash_out); end
    checks++; if (round_index !== '0) begin failures++; $display("FAIL reset_round_index: got %0d want 0", round_index); end
`ifdef W_ORDER_CHECK_EN
    checks++; if (order_error !== 1'b0) begin failures++; $display("FAIL reset_order_error: got %b want 0", order_error); end
`endif
    // Words offered while idle must not be consumed.
    w_if.w_valid = 1'b1; w_if.w_word = 32'hdeadbeef;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (round_index !== '0) begin failures++; $display("FAIL idle_word_ignored: round_index got %0d want 0", round_index); end
    checks++; if (w_if.w_ready !== 1'b0) begin failures++; $display("FAIL idle_w_ready: got %b want 0", w_if.w_ready); end
    w_if.w_valid = 1'b0;
  endtask

  task automatic test_abc_single();
    load_abc();
    run_block(IV, 1'b0, -1, -1, -1);
    checks++; if (blk_valid !== 1'b1) begin failures++; $display("FAIL abc_hash_valid_seen: got %b want 1", blk_valid); end
    checks++; if (blk_cycles != 66) begin failures++; $display("FAIL abc_latency: got %0d cycles want 66", blk_cycles); end
    checks++; if (blk_digest !== ABC_DIGEST) begin failures++; $display("FAIL abc_digest: got %h want %h", blk_digest, ABC_DIGEST); end
    checks++; if (blk_ready_c1 !== 1'b1) begin failures++; $display("FAIL abc_w_ready_after_start: got %b want 1", blk_ready_c1); end
    checks++; if (blk_busy_c1 !== 1'b1) begin failures++; $display("FAIL abc_busy_after_start: got %b want 1", blk_busy_c1); end
    checks++; if (blk_ri_bad != 0) begin failures++; $display("FAIL abc_round_index_track: got %0d bad cycles want 0", blk_ri_bad); end
    checks++; if (blk_busy_done !== 1'b1) begin failures++; $display("FAIL abc_busy_in_done: got %b want 1", blk_busy_done); end
    checks++; if (blk_ri_done !== IDX_W'(64)) begin failures++; $display("FAIL abc_round_index_sat: got %0d want 64", blk_ri_done); end
    @(posedge clk); #1;
    checks++; if (hash_valid !== 1'b0) begin failures++; $display("FAIL abc_valid_one_cycle: got %b want 0", hash_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abc_busy_after_done: got %b want 0", busy); end
    checks++; if (hash_out !== ABC_DIGEST) begin failures++; $display("FAIL abc_hash_hold: got %h want %h", hash_out, ABC_DIGEST); end
  endtask

  task automatic test_stalls();
    load_abc();
    run_block(IV, 1'b1, -1, -1, -1);
    checks++; if (blk_valid !== 1'b1) begin failures++; $display("FAIL stall_hash_valid_seen: got %b want 1", blk_valid); end
    checks++; if (blk_digest !== ABC_DIGEST) begin failures++; $display("FAIL stall_digest: got %h want %h", blk_digest, ABC_DIGEST); end
    checks++; if (blk_ri_bad != 0) begin failures++; $display("FAIL stall_round_index_track: got %0d bad cycles want 0", blk_ri_bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_two_block();
    logic [255:0] mid;
    load_msg1();
    run_block(IV, 1'b0, -1, -1, -1);
    mid = blk_digest;
    checks++; if (blk_valid !== 1'b1) begin failures++; $display("FAIL two_block1_valid: got %b want 1", blk_valid); end
    @(posedge clk); #1;
    load_msg2();
    run_block(mid, 1'b0, -1, -1, -1);
    checks++; if (blk_digest !== TWO_DIGEST) begin failures++; $display("FAIL two_block_digest: got %h want %h", blk_digest, TWO_DIGEST); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int bad_valid;
    int bad_ready;
    load_abc();
    run_block(IV, 1'b0, -1, 30, -1);
    checks++; if (blk_stopped !== 1'b1 || blk_valid !== 1'b0) begin failures++; $display("FAIL abort_reached_round30: stopped %b valid %b want 1 0", blk_stopped, blk_valid); end
    checks++; if (round_index !== IDX_W'(30)) begin failures++; $display("FAIL abort_round_index_before: got %0d want 30", round_index); end
    rst_n = 1'b0;
    #1;
    checks++; if (hash_out !== 256'h0) begin failures++; $display("FAIL abort_hash_out_zero: got %h want 0", hash_out); end
    checks++; if (busy !== 1'b0 || w_if.w_ready !== 1'b0 || hash_valid !== 1'b0) begin
      failures++; $display("FAIL abort_flags_zero: busy %b w_ready %b hash_valid %b want 0 0 0", busy, w_if.w_ready, hash_valid);
    end
    checks++; if (round_index !== '0) begin failures++; $display("FAIL abort_round_index_zero: got %0d want 0", round_index); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad_valid = 0; bad_ready = 0;
    w_if.w_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (hash_valid !== 1'b0) bad_valid++;
      if (w_if.w_ready !== 1'b0) bad_ready++;
    end
    w_if.w_valid = 1'b0;
    checks++; if (bad_valid != 0) begin failures++; $display("FAIL abort_no_partial_hash: got %0d valid cycles want 0", bad_valid); end
    checks++; if (bad_ready != 0) begin failures++; $display("FAIL abort_stays_idle: got %0d ready cycles want 0", bad_ready); end
    run_block(IV, 1'b0, -1, -1, -1);
    checks++; if (blk_digest !== ABC_DIGEST) begin failures++; $display("FAIL abort_next_digest: got %h want %h", blk_digest, ABC_DIGEST); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    load_abc();
    run_block(IV, 1'b0, 10, -1, -1);
    checks++; if (blk_cycles != 66) begin failures++; $display("FAIL restart_latency: got %0d cycles want 66", blk_cycles); end
    checks++; if (blk_digest !== ABC_DIGEST) begin failures++; $display("FAIL restart_digest: got %h want %h", blk_digest, ABC_DIGEST); end
    // Still in the DONE cycle: this start must be dropped.
    start = 1'b1; hash_in = ~IV;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_start_busy: got %b want 0", busy); end
    checks++; if (w_if.w_ready !== 1'b0) begin failures++; $display("FAIL done_start_w_ready: got %b want 0", w_if.w_ready); end
    @(posedge clk); #1;
    checks++; if (w_if.w_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL done_start_idle: w_ready %b busy %b want 0 0", w_if.w_ready, busy); end
    checks++; if (hash_out !== ABC_DIGEST) begin failures++; $display("FAIL done_start_hash_hold: got %h want %h", hash_out, ABC_DIGEST); end
  endtask

`ifdef W_ORDER_CHECK_EN
  task automatic test_order_check();
    load_abc();
    run_block(IV, 1'b0, -1, -1, 4);
    checks++; if (blk_bad_cycle < 0) begin failures++; $display("FAIL order_bad_word_sent: got %0d want >=0", blk_bad_cycle); end
    checks++; if (blk_oe_first != blk_bad_cycle + 1) begin failures++; $display("FAIL order_rise_cycle: got %0d want %0d", blk_oe_first, blk_bad_cycle + 1); end
    checks++; if (blk_oe_done !== 1'b1) begin failures++; $display("FAIL order_sticky_done: got %b want 1", blk_oe_done); end
    checks++; if (blk_digest !== ABC_DIGEST) begin failures++; $display("FAIL order_digest: got %h want %h", blk_digest, ABC_DIGEST); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (order_error !== 1'b1) begin failures++; $display("FAIL order_sticky_idle: got %b want 1", order_error); end
    run_block(IV, 1'b0, -1, -1, -1);
    checks++; if (blk_oe_any !== 1'b0) begin failures++; $display("FAIL order_clear_on_start: got %b want 0", blk_oe_any); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_abc_single();
    test_stalls();
    test_two_block();
    test_reset_abort();
    test_start_ignored();
`ifdef W_ORDER_CHECK_EN
    test_order_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
